// File: rtl/cd_stats_accum_tile.sv
// Contrastive-divergence statistics accumulator: sums v_i*h_j outer products into
// positive/negative Q7.23 banks and serves them through a 1-cycle registered read port.
module cd_stats_accum_tile #(
  parameter int I_TILE = 16,
  parameter int H_TILE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_phase,
  input  logic [16*I_TILE-1:0]  s_v,
  input  logic [16*H_TILE-1:0]  s_h,
  input  logic                  rd_lock,
  input  logic [15:0]           acc_addr,
  output logic [31:0]           acc_pos_d,
  output logic [31:0]           acc_neg_d,
  output logic                  busy,
  output logic                  sample_done,
  output logic [15:0]           n_pos,
  output logic [15:0]           n_neg
);

  localparam int N   = I_TILE * H_TILE;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int IIW = (I_TILE > 1) ? $clog2(I_TILE) : 1;
  localparam int HIW = (H_TILE > 1) ? $clog2(H_TILE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IW-1:0]         idx_r;
  logic [15:0]           v_r [I_TILE];
  logic [15:0]           h_r [H_TILE];
  logic                  phase_r;
  logic signed [24:0]    prod_sh_r;
  logic signed [31:0]    acc_old_r;
  logic                  wr_vld_r;
  logic [IW-1:0]         wr_idx_r;
  logic                  busy_r;
  logic                  sample_done_r;
  logic [15:0]           n_pos_r;
  logic [15:0]           n_neg_r;
  logic [31:0]           acc_pos_d_r;
  logic [31:0]           acc_neg_d_r;

  logic signed [31:0]    acc_pos_mem [N];
  logic signed [31:0]    acc_neg_mem [N];

  logic                  s_ready_s;
  logic                  accept_s;
  logic                  clear_go_s;
  logic                  issue_s;
  logic                  clr_wr_s;
  logic                  last_s;
  logic [31:0]           idx_ext_s;
  logic [IIW-1:0]        i_s;
  logic [HIW-1:0]        j_s;
  logic signed [32:0]    prod_s;
  logic signed [31:0]    wr_data_s;
  logic                  rd_hit_s;

  // Accumulate one Q1.23 addend into a Q7.23 word, clamping instead of wrapping.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [24:0] add);
    logic [33:0] sum;
    sum = {{2{acc[31]}}, acc} + {{9{add[24]}}, add};
    if ((sum[33:31] == 3'b000) || (sum[33:31] == 3'b111)) begin
      sat_add = sum[31:0];
    end else if (sum[33]) begin
      sat_add = 32'sh8000_0000;
    end else begin
      sat_add = 32'sh7FFF_FFFF;
    end
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; clear wins over a simultaneous sample
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_go_s) begin
          state_nxt_s = ST_CLEAR;
        end else if (accept_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DRAIN: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    s_ready_s  = (state_r == ST_IDLE) && !rd_lock;
    clear_go_s = s_ready_s && clear;
    accept_s   = s_ready_s && s_valid && !clear;
    issue_s    = (state_r == ST_ACCUM);
    clr_wr_s   = (state_r == ST_CLEAR);
    last_s     = (idx_r == IDX_LAST);
  end

  // Stage-1 element select and v_i*h_j product (signed v, unsigned h)
  always_comb begin
    idx_ext_s = 32'(idx_r);
    i_s       = IIW'(idx_ext_s / 32'(H_TILE));
    j_s       = HIW'(idx_ext_s % 32'(H_TILE));
    prod_s    = $signed({{17{v_r[i_s][15]}}, v_r[i_s]}) * $signed({17'd0, h_r[j_s]});
    wr_data_s = sat_add(acc_old_r, prod_sh_r);
    rd_hit_s  = (acc_addr < 16'(N));
  end

  // Index walk, status flags and saturating sample counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r         <= '0;
      busy_r        <= 1'b0;
      sample_done_r <= 1'b0;
      n_pos_r       <= 16'd0;
      n_neg_r       <= 16'd0;
    end else begin
      busy_r        <= (state_nxt_s != ST_IDLE);
      sample_done_r <= (state_r == ST_DRAIN);
      if ((issue_s || clr_wr_s) && !last_s) begin
        idx_r <= idx_r + IW'(1);
      end else begin
        idx_r <= '0;
      end
      if (clr_wr_s && last_s) begin
        n_pos_r <= 16'd0;
        n_neg_r <= 16'd0;
      end else if (accept_s && s_phase && (n_neg_r != 16'hFFFF)) begin
        n_neg_r <= n_neg_r + 16'd1;
      end else if (accept_s && !s_phase && (n_pos_r != 16'hFFFF)) begin
        n_pos_r <= n_pos_r + 16'd1;
      end else begin
        n_pos_r <= n_pos_r;
        n_neg_r <= n_neg_r;
      end
    end
  end

  // Sample capture on the accept edge; inputs are free to change afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      for (int k = 0; k < I_TILE; k++) v_r[k] <= 16'd0;
      for (int k = 0; k < H_TILE; k++) h_r[k] <= 16'd0;
    end else if (accept_s) begin
      phase_r <= s_phase;
      for (int k = 0; k < I_TILE; k++) v_r[k] <= s_v[16*k +: 16];
      for (int k = 0; k < H_TILE; k++) h_r[k] <= s_h[16*k +: 16];
    end else begin
      phase_r <= phase_r;
    end
  end

  // Stage-1 to stage-2 pipeline: scaled product, old accumulator, write target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_sh_r <= 25'sd0;
      acc_old_r <= 32'sd0;
      wr_vld_r  <= 1'b0;
      wr_idx_r  <= '0;
    end else begin
      wr_vld_r <= issue_s;
      if (issue_s) begin
        prod_sh_r <= 25'(prod_s >>> 8);
        acc_old_r <= phase_r ? acc_neg_mem[idx_r] : acc_pos_mem[idx_r];
        wr_idx_r  <= idx_r;
      end else begin
        prod_sh_r <= prod_sh_r;
        acc_old_r <= acc_old_r;
        wr_idx_r  <= wr_idx_r;
      end
    end
  end

  // Bank write port; banks are deliberately not reset
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      acc_pos_mem[idx_r] <= 32'sd0;
      acc_neg_mem[idx_r] <= 32'sd0;
    end else if (wr_vld_r && phase_r) begin
      acc_neg_mem[wr_idx_r] <= wr_data_s;
    end else if (wr_vld_r && !phase_r) begin
      acc_pos_mem[wr_idx_r] <= wr_data_s;
    end else begin
      acc_pos_mem[idx_r] <= acc_pos_mem[idx_r];
    end
  end

  // Registered read port; same-cycle writes are not forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pos_d_r <= 32'd0;
      acc_neg_d_r <= 32'd0;
    end else if (rd_hit_s) begin
      acc_pos_d_r <= acc_pos_mem[acc_addr[IW-1:0]];
      acc_neg_d_r <= acc_neg_mem[acc_addr[IW-1:0]];
    end else begin
      acc_pos_d_r <= 32'd0;
      acc_neg_d_r <= 32'd0;
    end
  end

  assign s_ready     = s_ready_s;
  assign busy        = busy_r;
  assign sample_done = sample_done_r;
  assign n_pos       = n_pos_r;
  assign n_neg       = n_neg_r;
  assign acc_pos_d   = acc_pos_d_r;
  assign acc_neg_d   = acc_neg_d_r;

endmodule

// File: tb/tb_cd_stats_accum_tile.sv
// Scoreboard bench for cd_stats_accum_tile: random and directed samples against an
// arithmetic reference of the accumulator banks, read back through the BRAM port.
module tb_cd_stats_accum_tile;

  localparam int I_T = 4;
  localparam int H_T = 4;
  localparam int N   = I_T * H_T;
  localparam int BUDGET = 4 * N + 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               s_valid;
  logic               s_ready;
  logic               s_phase;
  logic [16*I_T-1:0]  s_v;
  logic [16*H_T-1:0]  s_h;
  logic               rd_lock;
  logic [15:0]        acc_addr;
  logic [31:0]        acc_pos_d;
  logic [31:0]        acc_neg_d;
  logic               busy;
  logic               sample_done;
  logic [15:0]        n_pos;
  logic [15:0]        n_neg;

  cd_stats_accum_tile #(.I_TILE(I_T), .H_TILE(H_T)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_phase(s_phase), .s_v(s_v), .s_h(s_h), .rd_lock(rd_lock), .acc_addr(acc_addr),
    .acc_pos_d(acc_pos_d), .acc_neg_d(acc_neg_d), .busy(busy),
    .sample_done(sample_done), .n_pos(n_pos), .n_neg(n_neg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rd_issue = 1'b0;
  logic rd_seen;

  // Reference state: bank contents as plain integers and sample counts
  longint mp [N];
  longint mn [N];
  int np = 0;
  int nn = 0;

  typedef struct { longint pos; longint neg; int addr; } rd_exp_t;
  typedef struct { int cyc; int np; int nn; } done_exp_t;
  rd_exp_t   rdq [$];
  done_exp_t dq  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= rd_issue;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: read-port responses and sample completions
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_seen) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          rd_exp_t e;
          e = rdq.pop_front();
          chk($sformatf("rd_pos[%0d]", e.addr), longint'($signed(acc_pos_d)), e.pos);
          chk($sformatf("rd_neg[%0d]", e.addr), longint'($signed(acc_neg_d)), e.neg);
        end
      end
      if (sample_done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          done_exp_t d;
          d = dq.pop_front();
          chk("done_latency_cycle", cyc, d.cyc);
          chk("done_n_pos", n_pos, d.np);
          chk("done_n_neg", n_neg, d.nn);
        end
      end
    end
  end

  function automatic longint clamp32(input longint x);
    if (x > 64'sd2147483647)  return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic void model_sample(input bit ph, input logic [16*I_T-1:0] v,
                                       input logic [16*H_T-1:0] h);
    for (int i = 0; i < I_T; i++) begin
      for (int j = 0; j < H_T; j++) begin
        longint vi, hj, a;
        vi = longint'($signed(v[16*i +: 16]));
        hj = longint'(h[16*j +: 16]);
        a  = (vi * hj) >>> 8;
        if (ph) mn[i*H_T+j] = clamp32(mn[i*H_T+j] + a);
        else    mp[i*H_T+j] = clamp32(mp[i*H_T+j] + a);
      end
    end
    if (ph) nn = (nn < 65535) ? nn + 1 : nn;
    else    np = (np < 65535) ? np + 1 : np;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      mp[k] = 0;
      mn[k] = 0;
    end
    np = 0;
    nn = 0;
  endfunction

  task automatic send_sample(input bit ph, input logic [16*I_T-1:0] v,
                             input logic [16*H_T-1:0] h, output int acc_cyc);
    done_exp_t d;
    s_phase = ph;
    s_v     = v;
    s_h     = h;
    s_valid = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < BUDGET; t++) begin
      if (s_ready && !clear) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_v     = {$urandom, $urandom};
    s_h     = {$urandom, $urandom};
    if (acc_cyc < 0) begin
      chk("accept_timeout", 1, 0);
    end else begin
      model_sample(ph, v, h);
      d.cyc = acc_cyc + N + 1;
      d.np  = np;
      d.nn  = nn;
      dq.push_back(d);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < BUDGET) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    int n;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    n = 0;
    while (busy && n < BUDGET) begin
      n++;
      @(posedge clk); #1;
    end
    chk("clear_len", n, N);
    chk("clear_n_pos", n_pos, 0);
    chk("clear_n_neg", n_neg, 0);
  endtask

  task automatic read_one(input int a, input longint ep, input longint en);
    rd_exp_t e;
    e.addr = a;
    e.pos  = ep;
    e.neg  = en;
    rdq.push_back(e);
    acc_addr = 16'(a);
    rd_issue = 1'b1;
    @(posedge clk); #1;
    rd_issue = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) begin
      rd_exp_t e;
      e.addr = a;
      e.pos  = mp[a];
      e.neg  = mn[a];
      rdq.push_back(e);
      acc_addr = 16'(a);
      rd_issue = 1'b1;
      @(posedge clk); #1;
    end
    rd_issue = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2;
    logic [16*I_T-1:0] v;
    logic [16*H_T-1:0] h;

    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_phase = 1'b0;
    s_v = '0; s_h = '0; rd_lock = 1'b0; acc_addr = 16'd0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_busy", busy, 0);
    chk("rst_sample_done", sample_done, 0);
    chk("rst_acc_pos_d", acc_pos_d, 0);
    chk("rst_acc_neg_d", acc_neg_d, 0);
    chk("rst_n_pos", n_pos, 0);
    chk("rst_n_neg", n_neg, 0);
    chk("rst_s_ready", s_ready, 1);

    do_clear();
    read_all();

    // Single positive sample: 0.5 * 0.5 at element (0,0)
    v = '0; v[15:0] = 16'h4000;
    h = '0; h[15:0] = 16'h8000;
    send_sample(1'b0, v, h, c0);
    wait_idle();
    read_one(0, 64'sh0020_0000, 0);
    read_all();

    // Same vector in both phases, back to back
    do_clear();
    send_sample(1'b0, v, h, c0);
    send_sample(1'b1, v, h, c1);
    chk("b2b_spacing", c1 - c0, N + 2);
    wait_idle();
    read_one(0, 64'sh0020_0000, 64'sh0020_0000);
    chk("pair_n_pos", n_pos, 1);
    chk("pair_n_neg", n_neg, 1);

    // rd_lock blocks both samples and clear
    rd_lock = 1'b1;
    s_valid = 1'b1;
    s_v = {$urandom, $urandom};
    for (int t = 0; t < 4; t++) begin
      clear = (t == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      chk("lock_s_ready", s_ready, 0);
      chk("lock_busy", busy, 0);
    end
    clear = 1'b0; s_valid = 1'b0; rd_lock = 1'b0;
    chk("lock_n_pos", n_pos, 1);
    read_all();

    // Clear and sample in the same cycle: clear first, sample afterwards
    v = {$urandom, $urandom};
    h = {$urandom, $urandom};
    s_v = v; s_h = h; s_phase = 1'b1; s_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    clear = 1'b0;
    model_clear();
    chk("clr_prio_busy", busy, 1);
    chk("clr_prio_s_ready", s_ready, 0);
    send_sample(1'b1, v, h, c1);
    chk("clr_then_accept", c1 - c0, N + 1);
    wait_idle();
    read_all();

    // Random samples, mixed phases, some back to back
    for (int r = 0; r < 12; r++) begin
      v = {$urandom, $urandom};
      h = {$urandom, $urandom};
      send_sample(1'($urandom_range(0, 1)), v, h, c2);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    read_all();

    // Saturation: row 0 driven to +max, row 1 to -min
    do_clear();
    v = '0; v[15:0] = 16'h7FFF; v[31:16] = 16'h8000;
    h = '1;
    for (int r = 0; r < 260; r++) send_sample(1'b0, v, h, c2);
    wait_idle();
    read_one(0, 64'sh7FFF_FFFF, 0);
    read_one(H_T, -64'sh8000_0000, 0);
    read_all();

    // Asynchronous reset in the middle of a sample
    do_clear();
    v = {$urandom, $urandom};
    h = {$urandom, $urandom};
    send_sample(1'b0, v, h, c0);
    repeat (N / 2 - 1) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sample_done", sample_done, 0);
    chk("arst_acc_pos_d", acc_pos_d, 0);
    chk("arst_acc_neg_d", acc_neg_d, 0);
    chk("arst_n_pos", n_pos, 0);
    chk("arst_n_neg", n_neg, 0);
    dq.delete();
    rdq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_clear();
    v = {$urandom, $urandom};
    h = {$urandom, $urandom};
    send_sample(1'b1, v, h, c0);
    wait_idle();
    read_all();
    repeat (2) @(posedge clk);
    if (dq.size() != 0) chk("done_missing", dq.size(), 0);
    if (rdq.size() != 0) chk("rd_missing", rdq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_stats_accum_tile.md
# cd_stats_accum_tile

Producer side of the SGD weight-update accumulator interface. Accumulates contrastive-divergence outer products v_i·h_j over a batch into two banks (positive phase, negative phase) of I_TILE×H_TILE Q7.23 accumulators. It then serves them through a BRAM-style read port to the weight-update tile, which supplies `acc_addr` and consumes `acc_pos_d` / `acc_neg_d`.

## Interface
- I_TILE, 16, visible units per tile
- H_TILE, 16, hidden units per tile (N = I_TILE*H_TILE, flat index idx = i*H_TILE + j)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  1-cycle pulse; zeroes both banks and both sample counters; accepted only in IDLE
- s_valid  in  1  sample offered
- s_ready  out  1  sample accepted when s_valid&&s_ready
- s_phase  in  1  0 = positive bank, 1 = negative bank
- s_v  in  16*I_TILE  visible vector, element i at [16i+15:16i], signed Q1.15
- s_h  in  16*H_TILE  hidden probabilities, element j at [16j+15:16j], unsigned Q0.16
- rd_lock  in  1  held high by the updater while it reads; blocks new samples and clear
- acc_addr  in  16  read address 0..N-1
- acc_pos_d, acc_neg_d  out  32 each  signed Q7.23 bank contents at acc_addr, 1-cycle latency
- busy  out  1  high in CLEAR, ACCUM, DRAIN
- sample_done  out  1  1-cycle pulse when a sample's last write commits
- n_pos, n_neg  out  16 each  accepted-sample counts per phase, saturating at 65535

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN.
- IDLE:
  - s_ready = !rd_lock.
  - clear && !rd_lock → CLEAR. Clear has priority over a simultaneous s_valid; the sample is not accepted.
  - Handshake → latch s_v, s_h and s_phase into internal registers, idx←0, increment n_pos or n_neg → ACCUM.
- CLEAR: write 0 to idx in both banks, idx 0..N-1, one per cycle; at idx==N-1 → IDLE; n_pos←n_neg←0.
- ACCUM: two-stage pipeline, one element issued per cycle.
  - Stage 1 at idx: i = idx / H_TILE, j = idx % H_TILE. Compute p = v_i·h_j, 33-bit signed Q1.31, from sign-extended v and zero-extended h. Read acc[phase][idx].
  - Stage 2: a = p >>> 8 (Q1.23). Write acc + a, saturated to [-2^31, 2^31-1], back to the same idx.
  - At idx==N-1 → DRAIN.
- DRAIN: final write commits, sample_done=1 → IDLE.
- Only the bank selected by the latched phase is written; the other bank is untouched.
- rd_lock is ignored once a sample or clear is in progress; the updater must wait for !busy.
- Read port is always live; in ACCUM a read of the address being written returns the pre-write value.
- Accumulator arrays are not reset; contents are undefined until a CLEAR completes.

## Timing
- Reset values:
  - state IDLE, busy 0, sample_done 0, acc_pos_d 0, acc_neg_d 0, n_pos 0, n_neg 0, internal idx 0.
  - s_ready follows !rd_lock immediately after reset release.
- Asserting rst_n low mid-ACCUM or mid-CLEAR aborts at once; a partially updated bank stays as is, and a CLEAR is required.
- Sample throughput: N+1 cycles from the accept edge to sample_done, then 1 IDLE cycle before the next accept, i.e. N+2 cycles per sample.
- CLEAR takes N cycles; busy drops the cycle after the last zero write.
- Read latency: acc_addr presented at edge k produces data valid after edge k+1; registered outputs, no combinational path from acc_addr.
- s_ready is low for the whole of CLEAR, ACCUM and DRAIN; s_v and s_h may change after the accept edge.

## Test plan
- Reset then clear; read all N addresses → every acc_pos_d and acc_neg_d = 0, n_pos = n_neg = 0.
- Positive sample with v_0 = 0x4000 (0.5) and h_0 = 0x8000 (0.5), all other elements 0:
  - acc_pos[0] = 0x0020_0000 (0.25 Q7.23);
  - all other entries 0, acc_neg unchanged;
  - sample_done exactly N+1 cycles after accept.
- Same vector sent as phase 0 then phase 1 → acc_pos[0] − acc_neg[0] = 0; n_pos = n_neg = 1; back-to-back accept spacing is N+2 cycles.
- Repeated samples with v_i = 0x7FFF and h_j = 0xFFFF → accumulator saturates at 0x7FFF_FFFF and does not wrap; negative v (0x8000) saturates at 0x8000_0000.
- rd_lock high with s_valid high → s_ready = 0 and no state change; clear and s_valid in the same IDLE cycle → CLEAR runs and the sample is taken afterwards.
- rst_n asserted at idx = N/2 of ACCUM → outputs return to reset values asynchronously; after release, clear plus one sample gives the correct single-sample result.
